// File: rtl/img_sram_pkg.sv
// +--------------------------------------------------------------------------+
// | img_sram_pkg                                                             |
// | Shared SRAM control struct, pixel/index widths and TX FSM state type.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package img_sram_pkg;

    localparam int C_PIX_W  = 8;
    localparam int C_ADDR_W = 8;
    // One bit wider than the address so end-of-frame compares never wrap at 255
    localparam int C_IDX_W  = 9;
    localparam int C_CNT_W  = 3;

    typedef struct packed {
        logic                sense_en;
        logic                write_en;
        logic [C_ADDR_W-1:0] row;
        logic [C_ADDR_W-1:0] col;
        logic [C_PIX_W-1:0]  din;
    } img_sram_ctrl_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_READ  = 2'd1,
        TX_DRAIN = 2'd2
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/io_tx_fifo.sv
// +--------------------------------------------------------------------------+
// | io_tx_fifo                                                               |
// | Shift-style output buffer; entry 0 is the registered head.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module io_tx_fifo
    import img_sram_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
)
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   head,
    output logic [C_CNT_W-1:0] count
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_CNT_W-1:0] r_count;
    logic [C_CNT_W-1:0] w_wr_idx;

    // On a simultaneous pop the entries shift down first, so the new word lands one slot lower
    assign w_wr_idx = pop ? (r_count - C_CNT_W'(1)) : r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    r_mem[i] <= r_mem[i+1];
                end
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_wr_idx == C_CNT_W'(i)) begin
                        r_mem[i] <= din;
                    end
                end
            end
            r_count <= r_count + C_CNT_W'(push) - C_CNT_W'(pop);
        end
    end

    assign head  = r_mem[0];
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/io_tx_controller.sv
// +--------------------------------------------------------------------------+
// | io_tx_controller                                                         |
// | Reads an nrows x ncols image from SRAM and streams it out with a         |
// | valid/ready handshake. Optional dout_last port via IO_TX_LAST_EN.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module io_tx_controller
    import img_sram_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
)
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [7:0]         nrows,
    input  logic [7:0]         ncols,
    input  logic [C_PIX_W-1:0] sram_dout,
    output img_sram_ctrl_t     sram_ctrl,
    output logic [C_PIX_W-1:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               busy,
    output logic               done
`ifdef IO_TX_LAST_EN
    ,
    output logic               dout_last
`endif
);

    localparam logic [1:0] C_ST_IDLE  = 2'(TX_IDLE);
    localparam logic [1:0] C_ST_READ  = 2'(TX_READ);
    localparam logic [1:0] C_ST_DRAIN = 2'(TX_DRAIN);

`ifdef IO_TX_LAST_EN
    localparam int C_FIFO_W = C_PIX_W + 1;
`else
    localparam int C_FIFO_W = C_PIX_W;
`endif

    logic [1:0]          r_state;
    logic [C_IDX_W-1:0]  r_row;
    logic [C_IDX_W-1:0]  r_col;
    logic [C_IDX_W-1:0]  r_nrows;
    logic [C_IDX_W-1:0]  r_ncols;
    logic                r_inflight;

    logic [C_CNT_W-1:0]  w_count;
    logic [C_FIFO_W-1:0] w_head;
    logic [C_FIFO_W-1:0] w_fifo_din;
    logic [3:0]          w_occ;
    logic                w_pop;
    logic                w_issue;
    logic                w_last_rd;
    logic                w_start;
    logic                w_done;

    assign w_pop     = dout_valid & dout_ready;
    // Occupancy counts the in-flight read, less any entry leaving this cycle
    assign w_occ     = {1'b0, w_count} + 4'(r_inflight) - 4'(w_pop);
    assign w_issue   = (r_state == C_ST_READ) && (w_occ < 4'(FIFO_DEPTH));
    assign w_last_rd = (r_row == r_nrows - C_IDX_W'(1)) && (r_col == r_ncols - C_IDX_W'(1));
    assign w_start   = (r_state == C_ST_IDLE) && en && (nrows != 8'd0) && (ncols != 8'd0);
    assign w_done    = (r_state == C_ST_DRAIN) && (w_count == '0) && !r_inflight;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= C_ST_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_nrows    <= '0;
            r_ncols    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            case (r_state)
                C_ST_IDLE: begin
                    if (w_start) begin
                        r_state <= C_ST_READ;
                        r_nrows <= {1'b0, nrows};
                        r_ncols <= {1'b0, ncols};
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                C_ST_READ: begin
                    if (w_issue) begin
                        if (w_last_rd) begin
                            r_state <= C_ST_DRAIN;
                        end
                        if (r_col == r_ncols - C_IDX_W'(1)) begin
                            r_col <= '0;
                            r_row <= r_row + C_IDX_W'(1);
                        end else begin
                            r_col <= r_col + C_IDX_W'(1);
                        end
                    end
                end
                C_ST_DRAIN: begin
                    if (w_done) begin
                        r_state <= C_ST_IDLE;
                    end
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

`ifdef IO_TX_LAST_EN
    logic r_inflight_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight_last <= w_issue & w_last_rd;
        end
    end

    assign w_fifo_din = {r_inflight_last, sram_dout};
    assign dout       = w_head[C_PIX_W-1:0];
    assign dout_last  = w_head[C_PIX_W] & dout_valid;
`else
    assign w_fifo_din = sram_dout;
    assign dout       = w_head;
`endif

    io_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (C_FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (r_inflight),
        .pop   (w_pop),
        .din   (w_fifo_din),
        .head  (w_head),
        .count (w_count)
    );

    always_comb begin
        sram_ctrl          = '0;
        sram_ctrl.sense_en = 1'b1;
        sram_ctrl.write_en = 1'b0;
        sram_ctrl.row      = r_row[C_ADDR_W-1:0];
        sram_ctrl.col      = r_col[C_ADDR_W-1:0];
        sram_ctrl.din      = '0;
    end

    assign dout_valid = (w_count != '0);
    assign busy       = (r_state != C_ST_IDLE);
    assign done       = w_done;

endmodule

`default_nettype wire

// File: tb/tb_io_tx_controller.sv
// +--------------------------------------------------------------------------+
// | tb_io_tx_controller                                                      |
// | Directed, table-driven bench for io_tx_controller with an SRAM model.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_io_tx_controller;
    import img_sram_pkg::*;

    localparam int FIFO_DEPTH = 2;

    logic           clk = 1'b0;
    logic           rstn;
    logic           en;
    logic [7:0]     nrows;
    logic [7:0]     ncols;
    logic [7:0]     sram_dout;
    img_sram_ctrl_t sram_ctrl;
    logic [7:0]     dout;
    logic           dout_valid;
    logic           dout_ready;
    logic           busy;
    logic           done;
`ifdef IO_TX_LAST_EN
    logic           dout_last;
`endif

    int checks   = 0;
    int failures = 0;

    io_tx_controller #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .nrows      (nrows),
        .ncols      (ncols),
        .sram_dout  (sram_dout),
        .sram_ctrl  (sram_ctrl),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
`ifdef IO_TX_LAST_EN
        ,
        .dout_last  (dout_last)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix_of(input int r, input int c);
        return 8'(16 * r + c);
    endfunction

    // SRAM: data for the driven address appears one cycle later
    always @(posedge clk) sram_dout <= pix_of(int'(sram_ctrl.row), int'(sram_ctrl.col));

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 1) return (cyc % 2) == 0;
        if (mode == 2) return cyc >= 10;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int nr, input int nc, input int mode, input int exp_done);
        int         n;
        int         cyc;
        int         xfers;
        int         er;
        int         ec;
        int         done_cyc;
        int         first_valid;
        int         pix_bad;
        int         ctrl_bad;
        int         busy_bad;
        int         hold_bad;
        int         last_bad;
        logic [7:0] held;
        bit         held_v;
        n = nr * nc;
        xfers = 0; er = 0; ec = 0; done_cyc = -1; first_valid = -1;
        pix_bad = 0; ctrl_bad = 0; busy_bad = 0; hold_bad = 0; last_bad = 0;
        held = '0; held_v = 1'b0;
        nrows = 8'(nr);
        ncols = 8'(nc);
        en    = 1'b1;
        tick();
        // Scramble the inputs after the start edge; the frame must use latched dims
        nrows = 8'd3;
        ncols = 8'd2;
        for (cyc = 0; cyc < n * 4 + 40; cyc++) begin
            dout_ready = ready_for(mode, cyc);
            en         = (cyc == 1);
            if (!sram_ctrl.sense_en || sram_ctrl.write_en || (sram_ctrl.din != '0)) ctrl_bad++;
            if (!busy) busy_bad++;
            if (first_valid < 0 && dout_valid) first_valid = cyc;
            if (held_v && (dout != held)) hold_bad++;
            if (mode == 2 && cyc == 9) begin
                chk("stall_reads_col", int'(sram_ctrl.col), FIFO_DEPTH);
                chk("stall_reads_row", int'(sram_ctrl.row), 0);
            end
            held_v = dout_valid && !dout_ready;
            held   = dout;
            if (dout_valid && dout_ready) begin
                if (dout != pix_of(er, ec)) begin
                    if (pix_bad == 0)
                        $display("pixel %0d: dout=%02h want=%02h", xfers, dout, pix_of(er, ec));
                    pix_bad++;
                end
`ifdef IO_TX_LAST_EN
                if (dout_last != (xfers == n - 1)) last_bad++;
`endif
                xfers++;
                if (ec == nc - 1) begin
                    ec = 0;
                    er++;
                end else begin
                    ec++;
                end
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            tick();
        end
        en = 1'b0;
        chk("done_cycle", done_cyc, exp_done);
        chk("xfers_at_done", xfers, n);
        chk("first_valid_cycle", first_valid, 2);
        chk("pixel_order", pix_bad, 0);
        chk("sram_ctrl_const", ctrl_bad, 0);
        chk("busy_in_frame", busy_bad, 0);
        chk("stall_hold", hold_bad, 0);
        chk("dout_last", last_bad, 0);
        tick();
        chk("idle_after_done", int'({busy, done, dout_valid}), 0);
    endtask

    typedef struct {
        int nr;
        int nc;
        int mode;
        int exp_done;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int bad;
        vecs[0] = '{nr: 2,   nc: 3,   mode: 0, exp_done: 8};
        vecs[1] = '{nr: 1,   nc: 4,   mode: 1, exp_done: 9};
        vecs[2] = '{nr: 1,   nc: 8,   mode: 2, exp_done: 18};
        vecs[3] = '{nr: 1,   nc: 1,   mode: 0, exp_done: 3};
        vecs[4] = '{nr: 1,   nc: 255, mode: 0, exp_done: 257};
        vecs[5] = '{nr: 255, nc: 1,   mode: 0, exp_done: 257};

        rstn = 1'b0; en = 1'b0; nrows = '0; ncols = '0; dout_ready = 1'b0;
        tick();
        tick();
        chk("reset_outputs", int'({busy, done, dout_valid, dout}), 0);
        chk("reset_addr", int'({sram_ctrl.row, sram_ctrl.col}), 0);
        chk("reset_sense_en", int'(sram_ctrl.sense_en), 1);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].nr, vecs[i].nc, vecs[i].mode, vecs[i].exp_done);
        end

        // Zero dimensions are ignored
        bad = 0;
        dout_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            en    = 1'b1;
            nrows = (k < 6) ? 8'd0 : 8'd3;
            ncols = (k < 6) ? 8'd5 : 8'd0;
            tick();
            if (busy || done || dout_valid) bad++;
        end
        en = 1'b0;
        chk("zero_dims_ignored", bad, 0);

        // Reset in the middle of a frame, after three transfers
        nrows = 8'd2; ncols = 8'd3; en = 1'b1; dout_ready = 1'b1;
        tick();
        en = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("pre_reset_busy", int'(busy), 1);
        chk("pre_reset_dout", int'(dout), int'(pix_of(1, 0)));
        rstn = 1'b0;
        #1;
        chk("async_reset_outputs", int'({busy, done, dout_valid, dout}), 0);
        chk("async_reset_addr", int'({sram_ctrl.row, sram_ctrl.col}), 0);
`ifdef IO_TX_LAST_EN
        chk("async_reset_last", int'(dout_last), 0);
`endif
        tick();
        rstn = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (busy || done || dout_valid) bad++;
        end
        chk("no_resume_after_reset", bad, 0);
        run_frame(2, 3, 0, 8);

`ifdef IO_TX_LAST_EN
        run_frame(255, 255, 0, 65027);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
